// File: rtl/iso_rx_fifo_core.sv
// ISO7816 / UART character receiver with internal bit timing, optional parity check,
// T=0 error signalling (NACK) and a small receive FIFO towards the host.
module iso_rx_fifo_core #(
  parameter int unsigned CLOCK_PER_BIT_WIDTH = 13,
  parameter int unsigned DATA_BITS           = 8,
  parameter int unsigned FIFO_DEPTH_LOG2     = 2,
  parameter logic        START_BIT           = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           serialIn,
  input  logic [CLOCK_PER_BIT_WIDTH-1:0] clocksPerBit,
  input  logic                           stopBit2,
  input  logic                           parityEnable,
  input  logic                           oddParity,
  input  logic                           msbFirst,
  input  logic                           nackEnable,
  input  logic                           dataRead,
  input  logic                           ackFlags,
  output logic [DATA_BITS-1:0]           dataOut,
  output logic                           dataOutValid,
  output logic [FIFO_DEPTH_LOG2:0]       fifoLevel,
  output logic                           overrunErrorFlag,
  output logic                           frameErrorFlag,
  output logic                           nackOut,
  output logic                           startBit,
  output logic                           run,
  output logic                           endOfRx
);

  localparam int unsigned CpbW    = CLOCK_PER_BIT_WIDTH;
  localparam int unsigned BitCntW = $clog2(DATA_BITS + 1);
  localparam int unsigned PtrW    = FIFO_DEPTH_LOG2;
  localparam int unsigned LvlW    = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned Depth   = 1 << FIFO_DEPTH_LOG2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2,
    StNack
  } state_e;

  state_e               state_q;
  logic [CpbW-1:0]      cnt_q;
  logic [BitCntW-1:0]   bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic                 par_q;
  logic                 err_q;
  logic                 run_q;
  logic                 end_of_rx_q;
  logic                 nack_out_q;

  logic [CpbW-1:0]      half_etu;
  logic [CpbW-1:0]      last_cnt;
  logic                 sample_now;
  logic [BitCntW-1:0]   bit_idx;
  logic                 line_idle;

  assign half_etu   = clocksPerBit >> 1;
  assign last_cnt   = clocksPerBit - CpbW'(1);
  assign sample_now = (cnt_q == last_cnt);
  assign line_idle  = ~START_BIT;
  assign bit_idx    = msbFirst ? (BitCntW'(DATA_BITS - 1) - bit_cnt_q) : bit_cnt_q;

  // Place the current line sample at the data position selected by bit order.
  always_comb begin
    shift_d = shift_q;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (bit_idx == BitCntW'(i)) begin
        shift_d[i] = serialIn;
      end
    end
  end

  // Receive FSM; err_q collects parity/stop/NACK errors for the completion cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      err_q       <= 1'b0;
      run_q       <= 1'b0;
      end_of_rx_q <= 1'b0;
      nack_out_q  <= 1'b0;
    end else begin
      end_of_rx_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (serialIn == START_BIT) begin
            state_q <= StStart;
          end
        end
        StStart: begin
          if (cnt_q == half_etu) begin
            cnt_q <= '0;
            if (serialIn != START_BIT) begin
              state_q <= StIdle;
            end else begin
              state_q   <= StData;
              run_q     <= 1'b1;
              bit_cnt_q <= '0;
              par_q     <= 1'b0;
              err_q     <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CpbW'(1);
          end
        end
        StData: begin
          if (sample_now) begin
            cnt_q     <= '0;
            shift_q   <= shift_d;
            par_q     <= par_q ^ serialIn;
            bit_cnt_q <= bit_cnt_q + BitCntW'(1);
            if (bit_cnt_q == BitCntW'(DATA_BITS - 1)) begin
              state_q <= parityEnable ? StParity : StStop1;
            end
          end else begin
            cnt_q <= cnt_q + CpbW'(1);
          end
        end
        StParity: begin
          if (sample_now) begin
            cnt_q <= '0;
            if ((par_q ^ serialIn) != oddParity) begin
              err_q   <= 1'b1;
              state_q <= nackEnable ? StNack : StStop1;
            end else begin
              state_q <= StStop1;
            end
          end else begin
            cnt_q <= cnt_q + CpbW'(1);
          end
        end
        StStop1: begin
          if (sample_now) begin
            cnt_q <= '0;
            if (serialIn != line_idle) begin
              err_q <= 1'b1;
            end
            if (stopBit2) begin
              state_q <= StStop2;
            end else begin
              state_q     <= StIdle;
              run_q       <= 1'b0;
              end_of_rx_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CpbW'(1);
          end
        end
        StStop2: begin
          if (sample_now) begin
            cnt_q <= '0;
            if (serialIn != line_idle) begin
              err_q <= 1'b1;
            end
            state_q     <= StIdle;
            run_q       <= 1'b0;
            end_of_rx_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CpbW'(1);
          end
        end
        StNack: begin
          // Half an etu of guard, then one full etu of error signal; counter restarts between.
          if (!nack_out_q) begin
            if (cnt_q == half_etu - CpbW'(1)) begin
              cnt_q      <= '0;
              nack_out_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CpbW'(1);
            end
          end else if (sample_now) begin
            cnt_q       <= '0;
            nack_out_q  <= 1'b0;
            state_q     <= StIdle;
            run_q       <= 1'b0;
            end_of_rx_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CpbW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // FIFO control; the completed character is pushed in the cycle endOfRx is high.
  logic [DATA_BITS-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [LvlW-1:0]      level_q;
  logic [LvlW-1:0]      level_d;
  logic                 overrun_q;
  logic                 frame_q;
  logic                 overrun_d;
  logic                 frame_d;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop;
  logic                 push;
  logic                 good_char;
  logic                 overrun_set;
  logic                 frame_set;

  assign fifo_empty  = (level_q == '0);
  assign fifo_full   = (level_q == LvlW'(Depth));
  assign pop         = dataRead & ~fifo_empty;
  assign good_char   = end_of_rx_q & ~err_q;
  assign push        = good_char & (~fifo_full | pop);
  assign overrun_set = good_char & fifo_full & ~pop;
  assign frame_set   = end_of_rx_q & err_q;

  // Level and sticky flag next-state; a set in the same cycle wins over ackFlags.
  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LvlW'(1);
    end
    overrun_d = overrun_q;
    frame_d   = frame_q;
    if (ackFlags) begin
      overrun_d = 1'b0;
      frame_d   = 1'b0;
    end
    if (overrun_set) begin
      overrun_d = 1'b1;
    end
    if (frame_set) begin
      frame_d = 1'b1;
    end
  end

  // FIFO pointers, level and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      level_q   <= level_d;
      overrun_q <= overrun_d;
      frame_q   <= frame_d;
    end
  end

  // Storage array; contents are don't-care while the level says empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign dataOut          = fifo_empty ? '0 : mem_q[rd_ptr_q];
  assign dataOutValid     = ~fifo_empty;
  assign fifoLevel        = level_q;
  assign overrunErrorFlag = overrun_q;
  assign frameErrorFlag   = frame_q;
  assign nackOut          = nack_out_q;
  assign startBit         = (state_q == StStart);
  assign run              = run_q;
  assign endOfRx          = end_of_rx_q;

endmodule

// File: doc/iso_rx_fifo_core.md
# iso_rx_fifo_core

Parametrised ISO7816 / UART character receiver with internal bit timing, configurable data width, a receive FIFO and optional T=0 error signalling (NACK) on parity failure. It sits between the card I/O pad and the host register interface of the ISO7816 master. It replaces the single-register receiver plus external bit counter, so the host can absorb back-to-back characters without overrun.

## Interface
Parameters:
- CLOCK_PER_BIT_WIDTH, 13, width of clocksPerBit and of the internal bit counter
- DATA_BITS, 8, data bits per character (5..9)
- FIFO_DEPTH_LOG2, 2, FIFO holds 2**FIFO_DEPTH_LOG2 characters
- START_BIT, 1'b0, line level of the start bit; stop/idle level is ~START_BIT

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears everything
- serialIn  in  1  line input, already synchronised
- clocksPerBit  in  CLOCK_PER_BIT_WIDTH  clocks per elementary time unit (etu), >= 4, static during a character
- stopBit2  in  1  0: one stop bit, 1: two stop bits
- parityEnable  in  1  1: parity bit present and checked
- oddParity  in  1  1: data+parity has an odd number of ones
- msbFirst  in  1  1: first received data bit goes to bit DATA_BITS-1
- nackEnable  in  1  1: drive error signal on parity error (T=0)
- dataRead  in  1  pop FIFO head; ignored when empty
- ackFlags  in  1  clears overrunErrorFlag and frameErrorFlag
- dataOut  out  DATA_BITS  FIFO head, valid while dataOutValid
- dataOutValid  out  1  FIFO not empty
- fifoLevel  out  FIFO_DEPTH_LOG2+1  characters stored
- overrunErrorFlag  out  1  sticky: good character dropped, FIFO full
- frameErrorFlag  out  1  sticky: parity error or bad stop bit
- nackOut  out  1  1: pad must drive line to START_BIT level
- startBit  out  1  start edge seen, not yet validated
- run  out  1  character reception in progress
- endOfRx  out  1  one-cycle pulse at character completion

## Operation
- States: IDLE, START, DATA, PARITY, STOP1, STOP2, NACK.
- Internal counter cnt: cleared on every state entry, increments each clk in non-IDLE states.
- IDLE: serialIn==START_BIT -> START (regardless of flags; flags do not block reception).
- START: at cnt==clocksPerBit/2 (integer divide) sample; serialIn!=START_BIT -> IDLE (glitch, nothing recorded); else -> DATA, run=1.
- DATA: sample at cnt==clocksPerBit-1, shift into index bitCounter (msbFirst: DATA_BITS-1-bitCounter); accumulate parity; after DATA_BITS samples -> PARITY if parityEnable else STOP1.
- PARITY: sample at cnt==clocksPerBit-1; error = (ones(data)+bit) parity != oddParity. Error and nackEnable -> NACK, else -> STOP1.
- STOP1: sample at cnt==clocksPerBit-1; level != idle -> frame error. stopBit2 -> STOP2 else complete. STOP2 identical then complete.
- NACK: cnt 0..clocksPerBit/2-1 idle; nackOut=1 for the following clocksPerBit cycles; then complete with frame error; stop bits not checked.
- Complete (one cycle, returns to IDLE): endOfRx=1, run=0. No error and FIFO not full (after same-cycle pop) -> push. No error and full -> overrunErrorFlag=1, character dropped. Error -> frameErrorFlag=1, nothing pushed.
- Flags: set beats ackFlags in same cycle. dataOut combinational from FIFO head; pop and push same cycle allowed at any level, level unchanged.

## Timing
- Reset values: all outputs 0, FIFO empty, state IDLE, cnt 0.
- startBit = (state==START), combinational from state.
- Push visible (dataOutValid, fifoLevel) the cycle after endOfRx.
- Line-to-completion, no parity, 1 stop, no glitch: 1 + clocksPerBit/2+1 + (DATA_BITS+1)*clocksPerBit cycles from first START_BIT-level sample.
- FIFO pointers wrap modulo depth; fifoLevel saturates at 2**FIFO_DEPTH_LOG2.
- Reset asserted mid-character: immediate abort, nackOut released, FIFO emptied, no endOfRx.

## Test plan
- clocksPerBit=16, 8N1 lsb-first, byte 0xA5 -> dataOut=0xA5, dataOutValid=1, fifoLevel=1, no flags, endOfRx single pulse.
- msbFirst=1, parityEnable=1, oddParity=0, byte 0x3B correct parity -> dataOut=0x3B; flip parity bit -> frameErrorFlag=1, fifoLevel=0.
- Same parity error with nackEnable=1, clocksPerBit=372 -> nackOut high exactly 372 cycles starting 186 cycles after parity sample; ackFlags clears frameErrorFlag.
- Start pulse of 4 cycles at clocksPerBit=16 -> startBit then IDLE, run never 1, no push.
- Depth 4: send 5 characters without dataRead -> fifoLevel=4, overrunErrorFlag=1, head still first byte; pop with push in completion cycle when full -> no overrun.
- Assert reset during DATA of second character -> all outputs 0 next cycle; following clean character received normally.
